// File: rtl/pipe_pkg.sv
// Shared definitions for the fetch->decode stage buffer: occupancy encoding,
// default bubble instruction and the default beat layout.
package pipe_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 14;
    localparam logic [DEF_DATA_W-1:0] NOP_INSTR_DEF = 32'h0000_0013;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } occ_state_t;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] instr;
        logic [DEF_ADDR_W-1:0] addr;
    } beat_t;

endpackage

// File: rtl/pipe_slot.sv
// One payload register (instruction + address) with load, clear-to-NOP and hold.
module pipe_slot #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 14,
    parameter logic [DATA_W-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] load_instr,
    input  logic [ADDR_W-1:0] load_addr,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] addr
);

    logic [DATA_W-1:0] instr_reg;
    logic [ADDR_W-1:0] addr_reg;

    // Clear wins over load so a flush always leaves a clean bubble.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            instr_reg <= NOP_INSTR;
            addr_reg  <= '0;
        end else if (load) begin
            instr_reg <= load_instr;
            addr_reg  <= load_addr;
        end
    end

    assign instr = instr_reg;
    assign addr  = addr_reg;

endmodule

// File: rtl/pipe_stage_buf.sv
// Fetch->decode stage with valid/ready handshake, 2-entry skid buffer,
// synchronous flush and a saturating stall-cycle counter.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 14,
    parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(NOP_INSTR_DEF),
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic              up_valid_i,
    output logic              up_ready_o,
    input  logic [DATA_W-1:0] up_instr_i,
    input  logic [ADDR_W-1:0] up_addr_i,
    output logic              dn_valid_o,
    input  logic              dn_ready_i,
    output logic [DATA_W-1:0] dn_instr_o,
    output logic [ADDR_W-1:0] dn_addr_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    occ_state_t state_reg, state_next;
    logic ready_reg;
    logic [CNT_W-1:0] stall_cnt_reg;

    logic accept, drain;
    logic main_load, main_clear, main_from_skid;
    logic skid_load, skid_clear;
    logic [DATA_W-1:0] main_instr, skid_instr, main_load_instr;
    logic [ADDR_W-1:0] main_addr, skid_addr, main_load_addr;

    assign accept = up_valid_i & ready_reg;
    assign drain  = dn_valid_o & dn_ready_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= EMPTY;
            ready_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            ready_reg <= (state_next != FULL);
        end
    end

    always_comb begin
        state_next     = state_reg;
        main_load      = 1'b0;
        main_clear     = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
        if (flush_i) begin
            state_next = EMPTY;
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (accept) begin
                        state_next = HALF;
                        main_load  = 1'b1;
                    end
                end
                HALF: begin
                    if (accept && !drain) begin
                        state_next = FULL;
                        skid_load  = 1'b1;
                    end else if (!accept && drain) begin
                        state_next = EMPTY;
                        main_clear = 1'b1;
                    end else if (accept && drain) begin
                        main_load = 1'b1;
                    end
                end
                FULL: begin
                    if (drain) begin
                        state_next     = HALF;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clear     = 1'b1;
                    end
                end
                default: begin
                    state_next = EMPTY;
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end

    assign main_load_instr = main_from_skid ? skid_instr : up_instr_i;
    assign main_load_addr  = main_from_skid ? skid_addr  : up_addr_i;

    pipe_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NOP_INSTR(NOP_INSTR)) u_main (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (main_load),
        .clear      (main_clear),
        .load_instr (main_load_instr),
        .load_addr  (main_load_addr),
        .instr      (main_instr),
        .addr       (main_addr)
    );

    pipe_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NOP_INSTR(NOP_INSTR)) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (skid_load),
        .clear      (skid_clear),
        .load_instr (up_instr_i),
        .load_addr  (up_addr_i),
        .instr      (skid_instr),
        .addr       (skid_addr)
    );

    // Flush does not touch the counter: it measures downstream pressure, not pipeline contents.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
        end else if (dn_valid_o && !dn_ready_i && (stall_cnt_reg != CNT_MAX)) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

    assign up_ready_o  = ready_reg;
    assign dn_valid_o  = (state_reg != EMPTY);
    assign dn_instr_o  = main_instr;
    assign dn_addr_o   = main_addr;
    assign stall_cnt_o = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf; a second instance with a 4-bit counter
// shares the stimulus to exercise saturation.
module tb_pipe_stage_buf;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n, flush, up_valid, dn_ready;
    logic [31:0] up_instr;
    logic [13:0] up_addr;

    logic        up_ready, dn_valid;
    logic [31:0] dn_instr;
    logic [13:0] dn_addr;
    logic [15:0] stall_cnt;

    logic        s_up_ready, s_dn_valid;
    logic [31:0] s_dn_instr;
    logic [13:0] s_dn_addr;
    logic [3:0]  s_stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_buf dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush),
        .up_valid_i(up_valid), .up_ready_o(up_ready),
        .up_instr_i(up_instr), .up_addr_i(up_addr),
        .dn_valid_o(dn_valid), .dn_ready_i(dn_ready),
        .dn_instr_o(dn_instr), .dn_addr_o(dn_addr),
        .stall_cnt_o(stall_cnt)
    );

    pipe_stage_buf #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .flush_i(flush),
        .up_valid_i(up_valid), .up_ready_o(s_up_ready),
        .up_instr_i(up_instr), .up_addr_i(up_addr),
        .dn_valid_o(s_dn_valid), .dn_ready_i(dn_ready),
        .dn_instr_o(s_dn_instr), .dn_addr_o(s_dn_addr),
        .stall_cnt_o(s_stall_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [13:0] a);
        up_valid = v;
        up_addr  = a;
        up_instr = 32'hA500_0000 | {18'd0, a};
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end else begin
            $display("ok   %s: %h", name, got);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; dn_ready = 1'b0;
        drive(1'b1, 14'd99);
        repeat (3) tick();
        chk("reset dn_valid", {31'd0, dn_valid}, 32'd0);
        chk("reset dn_instr", dn_instr, NOP);
        chk("reset dn_addr", {18'd0, dn_addr}, 32'd0);
        chk("reset up_ready", {31'd0, up_ready}, 32'd0);
        chk("reset stall_cnt", {16'd0, stall_cnt}, 32'd0);
        drive(1'b0, 14'd0);
        rst_n = 1'b1;
        tick();
        chk("release up_ready", {31'd0, up_ready}, 32'd1);
        chk("release dn_valid", {31'd0, dn_valid}, 32'd0);
    endtask

    task automatic test_streaming();
        dn_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 14'(i));
            tick();
            chk($sformatf("stream%0d dn_valid", i), {31'd0, dn_valid}, 32'd1);
            chk($sformatf("stream%0d dn_addr", i), {18'd0, dn_addr}, i);
            chk($sformatf("stream%0d dn_instr", i), dn_instr, 32'hA500_0000 | i);
        end
        drive(1'b0, 14'd0);
        tick();
        chk("stream end dn_valid", {31'd0, dn_valid}, 32'd0);
        chk("stream end dn_instr", dn_instr, NOP);
        chk("stream end dn_addr", {18'd0, dn_addr}, 32'd0);
        chk("stream stall_cnt", {16'd0, stall_cnt}, 32'd0);
    endtask

    task automatic test_backpressure();
        dn_ready = 1'b0;
        drive(1'b1, 14'd10);                 // A
        tick();
        chk("bp A dn_addr", {18'd0, dn_addr}, 32'd10);
        chk("bp A up_ready", {31'd0, up_ready}, 32'd1);
        drive(1'b1, 14'd11);                 // B
        tick();
        chk("bp B up_ready", {31'd0, up_ready}, 32'd0);
        chk("bp B dn_addr held", {18'd0, dn_addr}, 32'd10);
        chk("bp B stall_cnt", {16'd0, stall_cnt}, 32'd1);
        drive(1'b1, 14'd12);                 // C, refused while full
        tick();
        chk("bp C1 dn_addr held", {18'd0, dn_addr}, 32'd10);
        chk("bp C1 up_ready", {31'd0, up_ready}, 32'd0);
        tick();
        chk("bp C2 dn_instr held", dn_instr, 32'hA500_000A);
        chk("bp C2 stall_cnt", {16'd0, stall_cnt}, 32'd3);
        dn_ready = 1'b1;
        tick();
        chk("bp drain1 dn_addr", {18'd0, dn_addr}, 32'd11);
        chk("bp drain1 up_ready", {31'd0, up_ready}, 32'd1);
        tick();
        chk("bp drain2 dn_addr", {18'd0, dn_addr}, 32'd12);
        drive(1'b0, 14'd0);
        tick();
        chk("bp end dn_valid", {31'd0, dn_valid}, 32'd0);
        chk("bp stall_cnt", {16'd0, stall_cnt}, 32'd3);
    endtask

    task automatic test_flush_full();
        dn_ready = 1'b0;
        drive(1'b1, 14'd20);
        tick();
        drive(1'b1, 14'd21);
        tick();
        chk("flush pre up_ready", {31'd0, up_ready}, 32'd0);
        flush = 1'b1;
        drive(1'b1, 14'd22);
        tick();
        chk("flush dn_valid", {31'd0, dn_valid}, 32'd0);
        chk("flush dn_instr", dn_instr, NOP);
        chk("flush dn_addr", {18'd0, dn_addr}, 32'd0);
        chk("flush up_ready", {31'd0, up_ready}, 32'd1);
        flush = 1'b0;
        drive(1'b0, 14'd0);
        dn_ready = 1'b1;
        tick();
        chk("flush dropped dn_valid", {31'd0, dn_valid}, 32'd0);
        chk("flush stall_cnt", {16'd0, stall_cnt}, 32'd5);
    endtask

    task automatic test_accept_drain_half();
        dn_ready = 1'b1;
        drive(1'b1, 14'd30);
        tick();
        for (int k = 1; k <= 5; k++) begin
            drive(1'b1, 14'(30 + k));
            tick();
            chk($sformatf("ad%0d dn_addr", k), {18'd0, dn_addr}, 30 + k);
            chk($sformatf("ad%0d up_ready", k), {31'd0, up_ready}, 32'd1);
        end
        drive(1'b0, 14'd0);
        tick();
        chk("ad end dn_valid", {31'd0, dn_valid}, 32'd0);
    endtask

    task automatic test_saturation();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("sat start cnt4", {28'd0, s_stall_cnt}, 32'd0);
        dn_ready = 1'b0;
        drive(1'b1, 14'd40);
        tick();
        drive(1'b0, 14'd0);
        repeat (10) tick();
        chk("sat mid cnt4", {28'd0, s_stall_cnt}, 32'd10);
        repeat (10) tick();
        chk("sat cnt4", {28'd0, s_stall_cnt}, 32'd15);
        chk("sat cnt16", {16'd0, stall_cnt}, 32'd20);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("sat flush cnt4", {28'd0, s_stall_cnt}, 32'd15);
        chk("sat flush cnt16", {16'd0, stall_cnt}, 32'd21);
        tick();
        chk("sat idle cnt16", {16'd0, stall_cnt}, 32'd21);
        rst_n = 1'b0;
        tick();
        chk("sat reset cnt4", {28'd0, s_stall_cnt}, 32'd0);
        chk("sat reset cnt16", {16'd0, stall_cnt}, 32'd0);
        chk("sat reset up_ready", {31'd0, up_ready}, 32'd0);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush_full();
        test_accept_drain_half();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
